// File: rtl/alu_exec_pipe.sv
// Two-stage execute pipe around an external combinational ALU: E holds the request and
// drives the ALU, W captures the result, the flags and the running accumulator.
package alu_pkg;
  typedef enum logic [2:0] {
    clr_alu  = 3'd0,
    pass_alu = 3'd1,
    add_alu  = 3'd2,
    sub_alu  = 3'd3,
    mul_alu  = 3'd4,
    inc_alu  = 3'd5
  } alu_op_t;
endpackage

module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  alu_op_t                 in_op,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic                    in_use_acc,
  input  logic                    acc_clr,
  output logic signed [WIDTH-1:0] alu_a,
  output logic signed [WIDTH-1:0] alu_b,
  output alu_op_t                 alu_sel,
  input  logic signed [WIDTH-1:0] alu_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic signed [WIDTH-1:0] acc
);

  logic                    vld_p0;
  alu_op_t                 op_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    use_acc_p0;

  logic w_adv;
  logic e_adv;
  logic accept;

  assign w_adv    = !out_valid || out_ready;
  assign e_adv    = vld_p0 && w_adv;
  assign in_ready = !vld_p0 || w_adv;
  assign accept   = in_valid && in_ready;

  // E stage: request register, drives the ALU
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_p0     <= 1'b0;
      op_p0      <= clr_alu;
      a_p0       <= '0;
      b_p0       <= '0;
      use_acc_p0 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0     <= 1'b1;
        op_p0      <= in_op;
        a_p0       <= in_a;
        b_p0       <= in_b;
        use_acc_p0 <= in_use_acc;
      end else if (e_adv) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Accumulator is read here, so the op behind always sees its predecessor's result.
  assign alu_sel = op_p0;
  assign alu_b   = b_p0;
  assign alu_a   = use_acc_p0 ? acc : a_p0;

  // W stage: result, flags and accumulator
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_neg   <= 1'b0;
    end else begin
      if (e_adv) begin
        out_valid <= 1'b1;
        out_data  <= alu_c;
        out_zero  <= (alu_c == '0);
        out_neg   <= alu_c[WIDTH-1];
      end else if (w_adv) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A clear wins over a retiring op; out_data still takes that op's result.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (e_adv) begin
      acc <= alu_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe with a behavioural ALU closing the loop on alu_c.
module tb_alu_exec_pipe;
  import alu_pkg::*;

  logic               clk = 1'b0;
  logic               rstN;
  logic               in_valid;
  logic               in_ready;
  alu_op_t            in_op;
  logic signed [11:0] in_a;
  logic signed [11:0] in_b;
  logic               in_use_acc;
  logic               acc_clr;
  logic signed [11:0] alu_a;
  logic signed [11:0] alu_b;
  alu_op_t            alu_sel;
  logic signed [11:0] alu_c;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_data;
  logic               out_zero;
  logic               out_neg;
  logic signed [11:0] acc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_pipe #(.WIDTH(12)) dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_neg(out_neg), .acc(acc)
  );

  // Reference ALU: wrapping 12-bit arithmetic, unknown selects give 0.
  always_comb begin
    alu_c = '0;
    case (alu_sel)
      clr_alu:  alu_c = '0;
      pass_alu: alu_c = alu_b;
      add_alu:  alu_c = alu_a + alu_b;
      sub_alu:  alu_c = alu_a - alu_b;
      mul_alu:  alu_c = alu_a * alu_b;
      inc_alu:  alu_c = alu_a + 12'sd1;
      default:  alu_c = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_op_t op, input logic signed [11:0] a,
                       input logic signed [11:0] b, input logic use_acc);
    in_valid   = 1'b1;
    in_op      = op;
    in_a       = a;
    in_b       = b;
    in_use_acc = use_acc;
    tick();
  endtask

  task automatic run_one(input alu_op_t op, input logic signed [11:0] a,
                         input logic signed [11:0] b, input logic use_acc);
    issue(op, a, b, use_acc);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rstN = 1'b0; in_valid = 1'b0; in_op = clr_alu; in_a = '0; in_b = '0;
    in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 12'(out_valid), 12'd0);
    chk("rst_acc",   acc,            12'd0);
    chk("rst_data",  out_data,       12'd0);
    chk("rst_zero",  12'(out_zero),  12'd1);
    chk("rst_neg",   12'(out_neg),   12'd0);
    chk("rst_ready", 12'(in_ready),  12'd1);
    rstN = 1'b1;
    tick();

    // single add
    run_one(add_alu, 12'sd5, 12'sd7, 1'b0);
    chk("add_valid", 12'(out_valid), 12'd1);
    chk("add_data",  out_data,       12'd12);
    chk("add_acc",   acc,            12'd12);
    chk("add_zero",  12'(out_zero),  12'd0);
    chk("add_neg",   12'(out_neg),   12'd0);
    tick();
    chk("add_drain", 12'(out_valid), 12'd0);

    // back-to-back chain through the accumulator
    issue(pass_alu, 12'sd0, 12'sd3, 1'b0);
    issue(inc_alu, 12'sd0, 12'sd0, 1'b1);
    chk("b2b_v0", 12'(out_valid), 12'd1);
    chk("b2b_d0", out_data,       12'd3);
    issue(mul_alu, 12'sd0, -12'sd2, 1'b1);
    chk("b2b_v1", 12'(out_valid), 12'd1);
    chk("b2b_d1", out_data,       12'd4);
    in_valid = 1'b0;
    tick();
    chk("b2b_v2",   12'(out_valid), 12'd1);
    chk("b2b_d2",   out_data,       12'hFF8);
    chk("b2b_neg",  12'(out_neg),   12'd1);
    tick();
    chk("b2b_drain", 12'(out_valid), 12'd0);

    // backpressure: two ops queued, a third held off until release
    out_ready = 1'b0;
    issue(add_alu, 12'sd1, 12'sd2, 1'b0);
    issue(add_alu, 12'sd10, 12'sd20, 1'b0);
    in_valid = 1'b1; in_op = add_alu; in_a = 12'sd100; in_b = 12'sd0; in_use_acc = 1'b0;
    #1;
    chk("bp_full_ready", 12'(in_ready), 12'd0);
    chk("bp_hold0",      out_data,      12'd3);
    tick();
    chk("bp_hold1",  out_data,       12'd3);
    chk("bp_valid1", 12'(out_valid), 12'd1);
    tick();
    chk("bp_hold2",  out_data,      12'd3);
    chk("bp_ready2", 12'(in_ready), 12'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 12'(in_ready), 12'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second", out_data,       12'd30);
    chk("bp_sv",     12'(out_valid), 12'd1);
    tick();
    chk("bp_third", out_data,       12'd100);
    chk("bp_tv",    12'(out_valid), 12'd1);
    tick();
    chk("bp_drain", 12'(out_valid), 12'd0);
    chk("bp_acc",   acc,            12'd100);

    // wrap and zero
    run_one(sub_alu, 12'sh800, 12'sd1, 1'b0);
    chk("wrap_data", out_data,      12'd2047);
    chk("wrap_neg",  12'(out_neg),  12'd0);
    run_one(sub_alu, 12'sd9, 12'sd9, 1'b0);
    chk("sub_zero_d", out_data,     12'd0);
    chk("sub_zero_f", 12'(out_zero), 12'd1);
    run_one(mul_alu, 12'sd64, 12'sd64, 1'b0);
    chk("mul_trunc_d", out_data,      12'd0);
    chk("mul_trunc_z", 12'(out_zero), 12'd1);
    run_one(alu_op_t'(3'd7), 12'sd5, 12'sd6, 1'b0);
    chk("badop_valid", 12'(out_valid), 12'd1);
    chk("badop_data",  out_data,       12'd0);

    // acc_clr coinciding with the op leaving E
    run_one(add_alu, 12'sd5, 12'sd7, 1'b0);
    chk("clr_pre_acc", acc, 12'd12);
    issue(add_alu, 12'sd1, 12'sd1, 1'b0);
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("clr_data",  out_data,       12'd2);
    chk("clr_valid", 12'(out_valid), 12'd1);
    chk("clr_acc",   acc,            12'd0);
    tick();

    // asynchronous reset while a result is stalled at the output
    out_ready = 1'b0;
    run_one(add_alu, 12'sd5, 12'sd7, 1'b0);
    chk("mid_valid", 12'(out_valid), 12'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("async_valid", 12'(out_valid), 12'd0);
    chk("async_acc",   acc,            12'd0);
    chk("async_ready", 12'(in_ready),  12'd1);
    chk("async_zero",  12'(out_zero),  12'd1);
    tick();
    rstN = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 12'(out_valid), 12'd0);
    chk("post_rst_data",  out_data,       12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
